// File: rtl/prog_loader_imem_if.sv
// rtl/prog_loader_imem_if.sv - byte-stream loader handshake bundle
interface prog_loader_imem_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/prog_loader_imem.sv
// rtl/prog_loader_imem.sv - instruction memory with big-endian byte-stream program loader
// Packs loaded bytes into 16-bit words and serves them combinationally once the program is complete.
module prog_loader_imem #(
  parameter int ADDR_W  = 10,
  parameter int INS_W   = 16,
  parameter int BITNESS = 16
) (
  input  logic                clk,
  input  logic                rst,
  prog_loader_imem_if.slave   ld,
  input  logic                reload,
  input  logic [BITNESS-1:0]  pc,
  output logic [INS_W-1:0]    ins,
  output logic                run,
  output logic [ADDR_W:0]     len,
  output logic                err_odd,
  output logic                err_ovf
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] LOAD_HI = 2'd0;
  localparam logic [1:0] LOAD_LO = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi;
  logic [INS_W-1:0]  mem [DEPTH];

  logic              xfer;
  logic              wr_en;
  logic [INS_W-1:0]  wr_data;
  logic              pc_in_range;

  assign ld.ld_ready = (state != RUN);
  assign run         = (state == RUN);
  assign xfer        = ld.ld_valid && ld.ld_ready;

  // Memory writes are suppressed whenever rst or reload would discard the byte anyway.
  assign wr_en   = xfer && !rst && !reload &&
                   ((state == LOAD_LO) || ((state == LOAD_HI) && ld.ld_last));
  assign wr_data = (state == LOAD_LO) ? INS_W'({hi, ld.ld_data}) : INS_W'({ld.ld_data, 8'h00});

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      state   <= LOAD_HI;
      addr    <= '0;
      len     <= '0;
      hi      <= '0;
      err_odd <= 1'b0;
      err_ovf <= 1'b0;
    end else if (xfer) begin
      case (state)
        LOAD_HI: begin
          if (ld.ld_last) begin
            len     <= len + 1'b1;
            err_odd <= 1'b1;
            state   <= RUN;
          end else begin
            hi    <= ld.ld_data;
            state <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          addr <= addr + 1'b1;
          len  <= len + 1'b1;
          if (ld.ld_last) begin
            state <= RUN;
          end else if (&addr) begin
            // Last word of the array just filled: stop loading rather than wrap.
            state   <= RUN;
            err_ovf <= 1'b1;
          end else begin
            state <= LOAD_HI;
          end
        end
        default: state <= LOAD_HI;
      endcase
    end
  end

  // Words beyond len are stale from an earlier program, so they read as the no-op.
  assign pc_in_range = ((pc >> ADDR_W) == '0) && ({1'b0, pc[ADDR_W-1:0]} < len);

  always_comb begin
    ins = '0;
    if ((state == RUN) && pc_in_range) begin
      ins = mem[pc[ADDR_W-1:0]];
    end
  end

endmodule

// File: tb/tb_prog_loader_imem.sv
// tb/tb_prog_loader_imem.sv - directed scoreboard bench for prog_loader_imem
module tb_prog_loader_imem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_imem_if ld0 ();
  prog_loader_imem_if ld1 ();

  logic        reload0, reload1;
  logic [15:0] pc0, pc1, ins0, ins1;
  logic        run0, run1, odd0, odd1, ovf0, ovf1;
  logic [10:0] len0;
  logic [2:0]  len1;

  prog_loader_imem dut0 (
    .clk(clk), .rst(rst), .ld(ld0), .reload(reload0), .pc(pc0), .ins(ins0),
    .run(run0), .len(len0), .err_odd(odd0), .err_ovf(ovf0)
  );

  prog_loader_imem #(.ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .ld(ld1), .reload(reload1), .pc(pc1), .ins(ins1),
    .run(run1), .len(len1), .err_odd(odd1), .err_ovf(ovf1)
  );

  typedef struct {
    int          sel;
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [7:0] m_hi;
  int         m_phase;
  int         m_idx;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_idx   = 0;
    m_hi    = 8'h00;
  endtask

  task automatic set_ld(int sel, logic v, logic [7:0] d, logic l);
    if (sel == 0) begin
      ld0.ld_valid = v; ld0.ld_data = d; ld0.ld_last = l;
    end else begin
      ld1.ld_valid = v; ld1.ld_data = d; ld1.ld_last = l;
    end
  endtask

  function automatic logic get_ready(int sel);
    return (sel == 0) ? ld0.ld_ready : ld1.ld_ready;
  endfunction

  function automatic logic get_run(int sel);
    return (sel == 0) ? run0 : run1;
  endfunction

  function automatic logic [15:0] get_ins(int sel);
    return (sel == 0) ? ins0 : ins1;
  endfunction

  task automatic set_pc(int sel, logic [15:0] v);
    if (sel == 0) pc0 = v;
    else          pc1 = v;
  endtask

  task automatic push_exp(int sel, logic [15:0] p, logic [15:0] i);
    exp_t e;
    e.sel = sel; e.pc = p; e.ins = i;
    sb.push_back(e);
  endtask

  // Drive one byte, wait (bounded) for acceptance, and record the expected word it completes.
  task automatic send_byte(int sel, logic [7:0] d, logic last);
    int n;
    @(negedge clk);
    set_ld(sel, 1'b1, d, last);
    n = 0;
    while (!get_ready(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ld_ready_wait", get_ready(sel), 1);
    @(posedge clk);
    #1;
    set_ld(sel, 1'b0, 8'h00, 1'b0);
    if (m_phase == 0) begin
      if (last) begin
        push_exp(sel, 16'(m_idx), {d, 8'h00});
        m_idx++;
      end else begin
        m_hi    = d;
        m_phase = 1;
      end
    end else begin
      push_exp(sel, 16'(m_idx), {m_hi, d});
      m_idx++;
      m_phase = 0;
    end
  endtask

  task automatic drain(string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      set_pc(e.sel, e.pc);
      #1;
      check(tag, get_ins(e.sel), e.ins);
    end
  endtask

  task automatic pulse_reload0();
    @(negedge clk);
    reload0 = 1'b1;
    @(posedge clk);
    #1;
    reload0 = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; reload0 = 1'b0; reload1 = 1'b0; pc0 = '0; pc1 = '0;
    set_ld(0, 1'b0, 8'h00, 1'b0);
    set_ld(1, 1'b0, 8'h00, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ld0.ld_ready, 1);
    check("rst_run", run0, 0);
    check("rst_len", len0, 0);
    check("rst_err_odd", odd0, 0);
    check("rst_err_ovf", ovf0, 0);
    check("rst_ins", ins0, 16'h0000);
    rst = 1'b0;

    // Case 1
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h6F, 0);
    send_byte(0, 8'h6F, 0);
    send_byte(0, 8'h00, 1);
    check("c1_run", run0, 1);
    check("c1_len", len0, 2);
    check("c1_ready", ld0.ld_ready, 0);
    push_exp(0, 16'd2, 16'h0000);
    drain("c1_ins");

    // Case 3: overflow on the small memory
    model_reset();
    for (int i = 1; i <= 8; i++) send_byte(1, 8'(i), 0);
    check("c3_run", run1, 1);
    check("c3_ovf", ovf1, 1);
    check("c3_odd", odd1, 0);
    check("c3_len", len1, 3'd4);
    drain("c3_ins");
    @(negedge clk);
    set_ld(1, 1'b1, 8'h09, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("c3_ready_blocked", ld1.ld_ready, 0);
    end
    set_ld(1, 1'b0, 8'h00, 1'b0);
    check("c3_len_after9", len1, 3'd4);
    pc1 = 16'd3;
    #1;
    check("c3_pc3", ins1, 16'h0708);

    // Case 2: odd byte count
    pulse_reload0();
    send_byte(0, 8'hAB, 0);
    send_byte(0, 8'hCD, 0);
    send_byte(0, 8'hEF, 1);
    check("c2_len", len0, 2);
    check("c2_odd", odd0, 1);
    check("c2_ovf", ovf0, 0);
    push_exp(0, 16'd2, 16'h0000);
    drain("c2_ins");

    // Case 4: gaps between bytes
    pulse_reload0();
    check("c4_reload_odd_clr", odd0, 0);
    send_byte(0, 8'h00, 0);
    @(negedge clk);
    send_byte(0, 8'h6F, 0);
    @(negedge clk);
    send_byte(0, 8'h6F, 0);
    @(negedge clk);
    check("c4_run_before_last", run0, 0);
    send_byte(0, 8'h00, 1);
    check("c4_run_after_last", run0, 1);
    check("c4_len", len0, 2);
    drain("c4_ins");

    // Case 5: out-of-range pc, reload, reload colliding with a byte
    pc0 = 16'h0400;
    #1;
    check("c5_pc_upper", ins0, 16'h0000);
    pc0 = 16'h0000;
    pulse_reload0();
    check("c5_run", run0, 0);
    check("c5_len", len0, 0);
    check("c5_ins", ins0, 16'h0000);
    @(negedge clk);
    reload0 = 1'b1;
    set_ld(0, 1'b1, 8'hEE, 1'b0);
    @(posedge clk);
    #1;
    reload0 = 1'b0;
    set_ld(0, 1'b0, 8'h00, 1'b0);
    model_reset();
    send_byte(0, 8'h12, 0);
    send_byte(0, 8'h34, 1);
    check("c5_len2", len0, 1);
    check("c5_odd", odd0, 0);
    drain("c5_ins2");

    // Case 6: rst in the middle of a load
    pulse_reload0();
    send_byte(0, 8'hA1, 0);
    send_byte(0, 8'hA2, 0);
    send_byte(0, 8'hA3, 0);
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("c6_len", len0, 0);
    check("c6_ready", ld0.ld_ready, 1);
    check("c6_run", run0, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h6F, 1);
    check("c6_len2", len0, 1);
    push_exp(0, 16'd1, 16'h0000);
    drain("c6_ins");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
